// File: rtl/lab5_pkg.sv
// rtl/lab5_pkg.sv - shared types and constants for the lab-5 LFSR encoder/decoder
//
// Contents:
//   LFSR_TAPS      six 6-bit tap masks, all maximal-length polynomials
//   PREAMBLE_CHAR  ASCII '_' prepended ahead of the message
//   PREL_MIN/MAX   legal preamble length range
//   state_t        controller states
//   clamp_prel     saturate a raw config byte into PREL_MIN..PREL_MAX
//   tap_mask       tap lookup; out-of-table indices fall back to entry 0
package lab5_pkg;

  localparam logic [5:0] LFSR_TAPS [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  localparam logic [7:0] PREAMBLE_CHAR = 8'h5F;
  localparam logic [3:0] PREL_MIN      = 4'd7;
  localparam logic [3:0] PREL_MAX      = 4'd12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD0  = 3'd1,
    LD1  = 3'd2,
    LD2  = 3'd3,
    ENC  = 3'd4,
    DONE = 3'd5
  } state_t;

  function automatic logic [3:0] clamp_prel(input logic [7:0] raw);
    if (raw < {4'b0, PREL_MIN})
      return PREL_MIN;
    else if (raw > {4'b0, PREL_MAX})
      return PREL_MAX;
    else
      return raw[3:0];
  endfunction

  // Indices 6 and 7 are not in the table and alias entry 0.
  function automatic logic [5:0] tap_mask(input logic [2:0] idx);
    case (idx)
      3'd1:    return LFSR_TAPS[1];
      3'd2:    return LFSR_TAPS[2];
      3'd3:    return LFSR_TAPS[3];
      3'd4:    return LFSR_TAPS[4];
      3'd5:    return LFSR_TAPS[5];
      default: return LFSR_TAPS[0];
    endcase
  endfunction

endpackage

// File: rtl/lfsr6_step.sv
// rtl/lfsr6_step.sv - combinational single step of a 6-bit Fibonacci LFSR
//
// Ports:
//   s     in  6  current LFSR state
//   taps  in  6  tap mask
//   s_nxt out 6  next state: shift left, parity of tapped bits into bit 0
module lfsr6_step (
  input  logic [5:0] s,
  input  logic [5:0] taps,
  output logic [5:0] s_nxt
);

  assign s_nxt = {s[4:0], ^(s & taps)};

endmodule

// File: rtl/lfsr_encoder.sv
// rtl/lfsr_encoder.sv - preamble + LFSR message scrambler driving dat_mem
//
// Reads prel/tap/seed from CFG_BASE..CFG_BASE+2, then writes MSG_LEN bytes
// to OUT_BASE.. : a clamped run of '_' followed by plaintext from mem[0..],
// each byte with its low 6 bits XORed with the LFSR state.
//
// Ports:
//   clk       in  1  clock
//   rst_n     in  1  asynchronous active-low reset
//   init      in  1  start request, sampled in IDLE only
//   data_out  in  8  combinational memory read data for raddr
//   raddr     out 8  memory read address
//   waddr     out 8  memory write address
//   data_in   out 8  memory write data
//   write_en  out 1  memory write strobe
//   busy      out 1  high from LD0 through DONE
//   done      out 1  one-cycle completion pulse
module lfsr_encoder
  import lab5_pkg::*;
#(
  parameter int MSG_LEN  = 64,
  parameter int CFG_BASE = 61,
  parameter int OUT_BASE = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic [7:0] data_out,
  output logic [7:0] raddr,
  output logic [7:0] waddr,
  output logic [7:0] data_in,
  output logic       write_en,
  output logic       busy,
  output logic       done
);

  state_t     state_q, state_d;
  logic [3:0] prel_q;
  logic [2:0] tap_idx_q;
  logic [5:0] lfsr_q;
  logic [5:0] lfsr_nxt;
  logic [7:0] k_q;
  logic       in_preamble;
  logic [7:0] plain;

  lfsr6_step u_step (
    .s     (lfsr_q),
    .taps  (tap_mask(tap_idx_q)),
    .s_nxt (lfsr_nxt)
  );

  // Outputs are decoded from registered state, so the asynchronous reset of
  // state_q also drops write_en and every other output the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (init) state_d = LD0;
      LD0:     state_d = LD1;
      LD1:     state_d = LD2;
      LD2:     state_d = ENC;
      ENC:     if (k_q == 8'(MSG_LEN - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prel_q    <= '0;
      tap_idx_q <= '0;
      lfsr_q    <= '0;
      k_q       <= '0;
    end else begin
      case (state_q)
        LD0: prel_q    <= clamp_prel(data_out);
        LD1: tap_idx_q <= (data_out[2:0] > 3'd5) ? 3'd0 : data_out[2:0];
        LD2: begin
          // An all-zero seed would lock the LFSR; substitute 1.
          lfsr_q <= (data_out[5:0] == 6'd0) ? 6'h01 : data_out[5:0];
          k_q    <= '0;
        end
        ENC: begin
          lfsr_q <= lfsr_nxt;
          k_q    <= k_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_preamble = (k_q < {4'b0, prel_q});

  always_comb begin
    raddr    = '0;
    waddr    = '0;
    data_in  = '0;
    write_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    plain    = '0;
    case (state_q)
      LD0: begin
        busy  = 1'b1;
        raddr = 8'(CFG_BASE);
      end
      LD1: begin
        busy  = 1'b1;
        raddr = 8'(CFG_BASE + 1);
      end
      LD2: begin
        busy  = 1'b1;
        raddr = 8'(CFG_BASE + 2);
      end
      ENC: begin
        busy     = 1'b1;
        write_en = 1'b1;
        waddr    = 8'(OUT_BASE) + k_q;
        if (in_preamble) begin
          plain = PREAMBLE_CHAR;
        end else begin
          raddr = k_q - {4'b0, prel_q};
          plain = data_out;
        end
        // Bits [7:6] of the plaintext pass through untouched.
        data_in = plain ^ {2'b00, lfsr_q};
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lfsr_encoder.sv
// tb/tb_lfsr_encoder.sv - directed self-checking bench for lfsr_encoder
module tb_lfsr_encoder;

  logic       clk;
  logic       rst_n;
  logic       init;
  logic [7:0] data_out;
  logic [7:0] raddr;
  logic [7:0] waddr;
  logic [7:0] data_in;
  logic       write_en;
  logic       busy;
  logic       done;

  logic [7:0] mem  [0:127];
  logic [7:0] snap [0:63];
  logic [5:0] seq  [0:63];
  logic [7:0] plain_ref [0:56];
  int         checks;
  int         errors;
  int         bad_wr;
  int         d1, d2;

  localparam logic [5:0] TB_TAPS [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  lfsr_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (init),
    .data_out (data_out),
    .raddr    (raddr),
    .waddr    (waddr),
    .data_in  (data_in),
    .write_en (write_en),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_out = mem[raddr[6:0]];

  always @(posedge clk) begin
    if (write_en) begin
      if (waddr < 8'd64) bad_wr++;
      mem[waddr[6:0]] <= data_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference LFSR sequence, bit-by-bit feedback.
  task automatic build_seq(input int tap, input logic [5:0] seed);
    logic [5:0] s;
    logic       fb;
    s = (seed == 6'd0) ? 6'h01 : seed;
    for (int k = 0; k < 64; k++) begin
      seq[k] = s;
      fb = 1'b0;
      for (int b = 0; b < 6; b++)
        if (TB_TAPS[tap][b]) fb = fb ^ s[b];
      s = {s[4:0], fb};
    end
  endtask

  task automatic setup(input logic [7:0] p, input logic [7:0] t, input logic [7:0] s);
    string msg;
    msg = "Mr. Watson";
    for (int i = 0; i < 61; i++) mem[i] = 8'h00;
    for (int i = 0; i < msg.len(); i++) mem[i] = msg[i];
    mem[61] = p;
    mem[62] = t;
    mem[63] = s;
    for (int i = 64; i < 128; i++) mem[i] = 8'hAA;
  endtask

  task automatic do_run(input int pulse_at, input bit hold, input int rst_at,
                        output int done1, output int done2);
    done1 = -1;
    done2 = -1;
    @(posedge clk); #1;
    init = 1'b1;
    for (int c = 0; c < 160; c++) begin
      if (c == 1 && !hold) init = 1'b0;
      if (hold && c == 70) init = 1'b0;
      if (pulse_at > 0 && c == pulse_at) init = 1'b1;
      if (pulse_at > 0 && c == pulse_at + 1) init = 1'b0;
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_write_en", write_en, 0);
        check("rst_busy", busy, 0);
        check("rst_raddr", raddr, 0);
        check("rst_waddr", waddr, 0);
        check("rst_data_in", data_in, 0);
        @(posedge clk); #1;
        check("rst_write_en_hold", write_en, 0);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      if (c == 1) check("busy_ld0", busy, 1);
      if (c == 4) begin
        check("enc0_we", write_en, 1);
        check("enc0_waddr", waddr, 64);
      end
      if (done) begin
        if (done1 < 0) done1 = c;
        else if (done2 < 0) done2 = c;
      end
      if (!hold && done1 >= 0 && c == done1 + 1) begin
        check("idle_busy", busy, 0);
        break;
      end
      if (hold && done2 >= 0 && c == done2 + 1) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic cmp_snap(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 64; k++) if (mem[64+k] !== snap[k]) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bad_wr = 0;
    init   = 1'b0;
    rst_n  = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_raddr", raddr, 0);
    check("reset_waddr", waddr, 0);
    check("reset_data_in", data_in, 0);
    check("reset_we", write_en, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;

    // Basic run: prel 7, tap 0, seed 1
    setup(8'd7, 8'd0, 8'h01);
    do_run(-1, 1'b0, -1, d1, d2);
    check("basic_done_cycle", d1, 68);
    check("basic_m64", mem[64], 8'h5E);
    check("basic_m65", mem[65], 8'h5C);
    check("basic_m66", mem[66], 8'h58);
    check("basic_m69", mem[69], 8'h60);
    check("basic_m70", mem[70], 8'h61);
    check("basic_m71", mem[71], 8'h70);
    check("basic_m72", mem[72], 8'h48);
    for (int k = 0; k < 64; k++) snap[k] = mem[64+k];

    // Zero seed equals seed 1
    setup(8'd7, 8'd0, 8'h00);
    do_run(-1, 1'b0, -1, d1, d2);
    cmp_snap("zero_seed");

    // Tap index 7 aliases to 0
    setup(8'd7, 8'd7, 8'h01);
    do_run(-1, 1'b0, -1, d1, d2);
    cmp_snap("tap7");

    // prel 3 clamps to 7
    setup(8'd3, 8'd0, 8'h01);
    do_run(-1, 1'b0, -1, d1, d2);
    check("prel3_m70", mem[70], 8'h61);
    check("prel3_m71", mem[71], 8'h70);
    cmp_snap("prel3");

    // prel 20 clamps to 12; last byte carries mem[51] incl. bits [7:6]
    setup(8'd20, 8'd0, 8'h01);
    mem[51] = 8'hC5;
    build_seq(0, 6'h01);
    do_run(-1, 1'b0, -1, d1, d2);
    check("prel20_m75", mem[75], 8'h5F ^ {2'b00, seq[11]});
    check("prel20_m76", mem[76], 8'h4D ^ {2'b00, seq[12]});
    check("prel20_m127", mem[127], 8'hC5 ^ {2'b00, seq[63]});

    // Loopback over every tap with random seed and prel
    for (int t = 0; t < 6; t++) begin
      logic [5:0] sd;
      logic [7:0] pl;
      int         bad;
      sd = 6'($urandom_range(0, 63));
      pl = 8'($urandom_range(7, 12));
      setup(pl, 8'(t), {2'b00, sd});
      for (int i = 0; i < 57; i++) begin
        plain_ref[i] = 8'($urandom);
        mem[i] = plain_ref[i];
      end
      build_seq(t, sd);
      do_run(-1, 1'b0, -1, d1, d2);
      bad = 0;
      for (int k = 0; k < 64; k++) begin
        logic [7:0] dec;
        dec = mem[64+k] ^ {2'b00, seq[k]};
        if (k < int'(pl)) begin
          if (dec !== 8'h5F) bad++;
        end else if (dec !== plain_ref[k - int'(pl)]) bad++;
      end
      check($sformatf("loopback_tap%0d", t), bad, 0);
      check($sformatf("loopback_done_tap%0d", t), d1, 68);
    end

    // init pulse mid-run is ignored
    setup(8'd7, 8'd0, 8'h01);
    do_run(30, 1'b0, -1, d1, d2);
    check("pulse_done_cycle", d1, 68);
    check("pulse_no_second", d2, -1);
    cmp_snap("pulse_data");

    // init held high: back-to-back runs
    setup(8'd7, 8'd0, 8'h01);
    do_run(-1, 1'b1, -1, d1, d2);
    check("hold_done1", d1, 68);
    check("hold_done2", d2, 137);

    // reset in cycle 40 stops writes before mem[100]
    setup(8'd7, 8'd0, 8'h01);
    do_run(-1, 1'b0, 40, d1, d2);
    repeat (3) @(posedge clk);
    #1;
    begin
      int bad;
      bad = 0;
      for (int i = 100; i < 128; i++) if (mem[i] !== 8'hAA) bad++;
      check("rst_mem_untouched", bad, 0);
    end
    check("rst_idle_we", write_en, 0);
    do_run(-1, 1'b0, -1, d1, d2);
    check("rst_rerun_done", d1, 68);
    cmp_snap("rst_rerun_data");

    check("write_range", bad_wr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_encoder.md
# lfsr_encoder

Message scrambler that produces the encrypted image consumed by the lab-5 LFSR decoder. On `init` it reads its configuration and plaintext from data memory. It prepends a run of ASCII `_` (0x5F) preamble characters, XORs every character's low 6 bits with a 6-bit maximal-length LFSR sequence, and writes 64 encrypted bytes to mem[64..127]. It sits beside `dat_mem` in the lab top level and drives the memory ports directly.

## Interface
- `MSG_LEN`, 64: number of encrypted bytes written.
- `CFG_BASE`, 61: address of the first config byte (prel, tap index, seed at 61/62/63).
- `OUT_BASE`, 64: first output address.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `init`  in  1  start request, level-sampled in IDLE only.
- `data_out`  in  8  dat_mem combinational read data for `raddr`.
- `raddr`  out  8  memory read address.
- `waddr`  out  8  memory write address.
- `data_in`  out  8  memory write data.
- `write_en`  out  1  memory write strobe; dat_mem writes on posedge when high.
- `busy`  out  1  high from the first LDCFG cycle through the DONE cycle.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Reset values: `raddr`=0, `waddr`=0, `data_in`=0, `write_en`=0, `busy`=0, `done`=0, state=IDLE, all internal registers 0.
- FSM states and transitions:
  - IDLE: if `init`=1 at posedge, go to LD0.
  - LD0: `raddr`=61; at posedge, prel ← clamp(data_out, 7, 12).
  - LD1: `raddr`=62; at posedge, tap_idx ← data_out[2:0]. Values 6 and 7 map to 0.
  - LD2: `raddr`=63; at posedge, lfsr ← data_out[5:0]. A seed of 0 is replaced by 6'h01.
  - ENC: runs 64 cycles with k = 0..63, then goes to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Tap table, indexed 0..5: 6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39.
- ENC cycle k:
  - p = 8'h5F if k < prel, else data_out with `raddr` = k−prel.
  - When k < prel, `raddr` is don't-care; drive it to 0.
  - `data_in` = p ^ {2'b00, lfsr}; `waddr` = 64+k; `write_en`=1.
  - At posedge, lfsr ← {lfsr[4:0], ^(lfsr & taps[tap_idx])}, a 6-bit shift with the parity of the tapped bits entering bit 0.
- `raddr` for k ≥ prel never exceeds 63−7 = 56. Writes touch only 64..127.
- Plaintext bits [7:6] pass through unmodified.
- `init` is ignored while `busy`. If `init` is still high in the IDLE cycle after DONE, a new run starts.
- Deasserting `rst_n` in any state immediately forces every output to its reset value, including `write_en`=0 asynchronously. No further writes occur until a new `init`.

## Timing
- Cycle 0 is the cycle in which `init` is sampled high in IDLE.
- Cycles 1–3: LD0–LD2. Cycles 4–67: ENC (64 writes, one per cycle). Cycle 68: DONE, `done`=1.
- Cycle 69: IDLE, `busy`=0.
- Start-to-done latency is 68 cycles.
- Memory read is combinational; the encoder uses `data_out` in the same cycle `raddr` is driven. No read pipelining.
- The write for character k commits at the posedge ending ENC cycle k.

## Structure
- Package `lab5_pkg`:
  - `LFSR_TAPS[6]` table.
  - `PREAMBLE_CHAR` = 8'h5F.
  - `PREL_MIN`=7, `PREL_MAX`=12.
  - `state_t` enum {IDLE, LD0, LD1, LD2, ENC, DONE}.
  - The decoder shares this package.
- Sub-module `lfsr6_step`: combinational next-state `{s[4:0], ^(s & taps)}`. The decoder reuses it.
- `dat_mem` is instantiated at top level, not inside this block.

## Test plan
- Basic run: prel=7, tap_idx=0, seed=0x01, message "Mr. Watson" at mem[0..] -> mem[64]=0x5E, mem[65]=0x5C (lfsr=0x03), mem[71]='M'^lfsr7; `done` is high exactly in cycle 68.
- Zero seed: seed=0x00 -> output is byte-identical to the seed=0x01 run. Tap index 7 -> identical to tap index 0.
- Clamping: prel=3 -> exactly 7 preamble characters. prel=20 -> 12 preamble characters, and mem[127] encodes mem[51].
- Loopback: every tap_idx 0..5 with random seed and prel 7..12 -> the downstream decoder restores the original plaintext in mem[0..]. Round-trip must be bit-exact.
- Init while busy: `init` pulsed in cycle 30 -> ignored, done still in cycle 68. `init` held high -> second run starts in cycle 69.
- Reset mid-run: `rst_n` low in cycle 40 -> `write_en`=0 immediately, mem[100..127] unchanged, and a fresh `init` completes a normal run.
